// File: rtl/sram_like_arbiter.sv
// Merges NUM_CH sram-like masters onto one sram-like slave port and routes each
// in-order slave response back to the channel that issued it, via an ID FIFO.
module sram_like_arbiter #(
    parameter int NUM_CH          = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int ARB_MODE        = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            m_req,
    input  logic [NUM_CH-1:0]            m_wr,
    input  logic [2*NUM_CH-1:0]          m_size,
    input  logic [DATA_W/8*NUM_CH-1:0]   m_wstrb,
    input  logic [ADDR_W*NUM_CH-1:0]     m_addr,
    input  logic [DATA_W*NUM_CH-1:0]     m_wdata,
    output logic [NUM_CH-1:0]            m_addr_ok,
    output logic [NUM_CH-1:0]            m_data_ok,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         s_req,
    output logic                         s_wr,
    output logic [1:0]                   s_size,
    output logic [DATA_W/8-1:0]          s_wstrb,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic                         s_addr_ok,
    input  logic                         s_data_ok,
    input  logic [DATA_W-1:0]            s_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                         err_unexp
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] ch_addr  [NUM_CH];
    logic [DATA_W-1:0] ch_wdata [NUM_CH];
    logic [STRB_W-1:0] ch_wstrb [NUM_CH];
    logic [1:0]        ch_size  [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_addr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
            assign ch_wdata[gi] = m_wdata[gi*DATA_W +: DATA_W];
            assign ch_wstrb[gi] = m_wstrb[gi*STRB_W +: STRB_W];
            assign ch_size[gi]  = m_size[gi*2 +: 2];
        end
    endgenerate

    logic [CH_W-1:0]  fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W:0]   wr_ptr_reg, rd_ptr_reg;
    logic             lock_valid_reg;
    logic [CH_W-1:0]  lock_idx_reg;
    logic [CH_W-1:0]  rr_ptr_reg;
    logic             err_unexp_reg;

    logic             fifo_full, fifo_empty, push, pop;
    logic [CH_W-1:0]  head_id;
    logic [NUM_CH-1:0] eligible;
    logic             grant_valid;
    logic [CH_W-1:0]  grant_idx;
    int               idx;

    assign outstanding = wr_ptr_reg - rd_ptr_reg;
    assign fifo_full   = (outstanding == (PTR_W+1)'(MAX_OUTSTANDING));
    assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
    assign head_id     = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

    // Reset also masks eligibility so nothing reaches the slave while reset is held.
    always_comb begin
        eligible    = (reset || fifo_full) ? '0 : m_req;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (lock_valid_reg && eligible[lock_idx_reg]) begin
            grant_valid = 1'b1;
            grant_idx   = lock_idx_reg;
        end else if (ARB_MODE == 0) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (eligible[k]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_W'(k);
                end
            end
        end else begin
            // Descending scan so the channel nearest the rr pointer is the last writer.
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr_reg) + k) % NUM_CH;
                if (eligible[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_W'(idx);
                end
            end
        end
    end

    assign push    = grant_valid & s_addr_ok;
    assign pop     = s_data_ok & ~fifo_empty;
    assign s_req   = grant_valid;
    assign s_wr    = m_wr[grant_idx];
    assign s_size  = ch_size[grant_idx];
    assign s_wstrb = ch_wstrb[grant_idx];
    assign s_addr  = ch_addr[grant_idx];
    assign s_wdata = ch_wdata[grant_idx];
    assign m_rdata = s_rdata;
    assign err_unexp = err_unexp_reg;

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_resp
            assign m_addr_ok[gi] = push && (grant_idx == CH_W'(gi));
            assign m_data_ok[gi] = pop && (head_id == CH_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= grant_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            lock_valid_reg <= 1'b0;
            lock_idx_reg   <= '0;
            rr_ptr_reg     <= '0;
            err_unexp_reg  <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            // A presented-but-unaccepted request keeps its channel until accepted or withdrawn.
            lock_valid_reg <= grant_valid & ~s_addr_ok;
            lock_idx_reg   <= grant_idx;
            if (push && ARB_MODE == 1)
                rr_ptr_reg <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
            if (s_data_ok && fifo_empty)
                err_unexp_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: a 2-channel fixed-priority instance driven from a vector table,
// plus a 4-channel round-robin instance and reset corner cases by hand.
module tb_sram_like_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    localparam logic [31:0] A0 = 32'h0000_1000, A1 = 32'h0000_2004;
    localparam logic [31:0] W0 = 32'hA0A0_0000, W1 = 32'hB1B1_1111;

    // fixed-priority instance
    logic [1:0]  d_req, d_addr_ok, d_data_ok;
    logic [1:0]  d_wr = 2'b10;
    logic [3:0]  d_size = {2'd1, 2'd2};
    logic [7:0]  d_wstrb = {4'h3, 4'hf};
    logic [63:0] d_addr = {A1, A0};
    logic [63:0] d_wdata = {W1, W0};
    logic [31:0] d_rdata, d_s_rdata, d_s_addr, d_s_wdata;
    logic        d_s_req, d_s_wr, d_aok, d_dok, d_err;
    logic [1:0]  d_s_size;
    logic [3:0]  d_s_wstrb;
    logic [2:0]  d_out;

    sram_like_arbiter #(.NUM_CH(2), .MAX_OUTSTANDING(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut0 (
        .clk(clk), .reset(reset),
        .m_req(d_req), .m_wr(d_wr), .m_size(d_size), .m_wstrb(d_wstrb),
        .m_addr(d_addr), .m_wdata(d_wdata),
        .m_addr_ok(d_addr_ok), .m_data_ok(d_data_ok), .m_rdata(d_rdata),
        .s_req(d_s_req), .s_wr(d_s_wr), .s_size(d_s_size), .s_wstrb(d_s_wstrb),
        .s_addr(d_s_addr), .s_wdata(d_s_wdata),
        .s_addr_ok(d_aok), .s_data_ok(d_dok), .s_rdata(d_s_rdata),
        .outstanding(d_out), .err_unexp(d_err)
    );

    // round-robin instance
    logic [3:0]   r_req, r_addr_ok, r_data_ok;
    logic [3:0]   r_wr = 4'b0000;
    logic [7:0]   r_size = 8'h00;
    logic [15:0]  r_wstrb = 16'h0000;
    logic [127:0] r_addr = {32'h40, 32'h30, 32'h20, 32'h10};
    logic [127:0] r_wdata = 128'h0;
    logic [31:0]  r_rdata, r_s_rdata, r_s_addr, r_s_wdata;
    logic         r_s_req, r_s_wr, r_aok, r_dok, r_err;
    logic [1:0]   r_s_size;
    logic [3:0]   r_s_wstrb;
    logic [2:0]   r_out;

    sram_like_arbiter #(.NUM_CH(4), .MAX_OUTSTANDING(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut1 (
        .clk(clk), .reset(reset),
        .m_req(r_req), .m_wr(r_wr), .m_size(r_size), .m_wstrb(r_wstrb),
        .m_addr(r_addr), .m_wdata(r_wdata),
        .m_addr_ok(r_addr_ok), .m_data_ok(r_data_ok), .m_rdata(r_rdata),
        .s_req(r_s_req), .s_wr(r_s_wr), .s_size(r_s_size), .s_wstrb(r_s_wstrb),
        .s_addr(r_s_addr), .s_wdata(r_s_wdata),
        .s_addr_ok(r_aok), .s_data_ok(r_dok), .s_rdata(r_s_rdata),
        .outstanding(r_out), .err_unexp(r_err)
    );

    typedef struct {
        logic [1:0]  req;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        exp_sreq;
        logic        exp_ch;
        logic [1:0]  exp_aok;
        logic [1:0]  exp_dok;
        logic [2:0]  exp_out;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] one;
        one = 4'b0001;
        //                req    aok   dok   rdata         sreq  ch    aok    dok    out   err
        vecs.push_back('{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b00, 3'd0, 1'b0}); // first grant ch0, held
        vecs.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 3'd0, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 3'd1, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 1'b1, 32'h1111_0001, 1'b1, 1'b0, 2'b01, 2'b01, 3'd2, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 1'b1, 32'h1111_0002, 1'b1, 1'b0, 2'b01, 2'b01, 3'd2, 1'b0});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 32'h1111_0003, 1'b0, 1'b0, 2'b00, 2'b01, 3'd2, 1'b0});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 32'h1111_0004, 1'b0, 1'b0, 2'b00, 2'b01, 3'd1, 1'b0});
        // lock: ch1 waits 3 cycles, ch0 arrives meanwhile
        vecs.push_back('{2'b10, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 2'b00, 2'b00, 3'd0, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 2'b00, 2'b00, 3'd0, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 2'b00, 2'b00, 3'd0, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 2'b10, 2'b00, 3'd0, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 3'd1, 1'b0});
        // lock released by the locked channel withdrawing
        vecs.push_back('{2'b10, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 2'b00, 2'b00, 3'd2, 1'b0});
        vecs.push_back('{2'b01, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b00, 3'd2, 1'b0});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 32'h2222_0001, 1'b0, 1'b0, 2'b00, 2'b10, 3'd2, 1'b0});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 32'h2222_0002, 1'b0, 1'b0, 2'b00, 2'b01, 3'd1, 1'b0});
        // fill the FIFO: 1,0,1,0
        vecs.push_back('{2'b10, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 2'b10, 2'b00, 3'd0, 1'b0});
        vecs.push_back('{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 3'd1, 1'b0});
        vecs.push_back('{2'b10, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 2'b10, 2'b00, 3'd2, 1'b0});
        vecs.push_back('{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 3'd3, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 3'd4, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 1'b1, 32'h3333_0001, 1'b0, 1'b0, 2'b00, 2'b10, 3'd4, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b00, 3'd3, 1'b0});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 32'h3333_0002, 1'b0, 1'b0, 2'b00, 2'b01, 3'd3, 1'b0});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 32'h3333_0003, 1'b0, 1'b0, 2'b00, 2'b10, 3'd2, 1'b0});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 32'h3333_0004, 1'b0, 1'b0, 2'b00, 2'b01, 3'd1, 1'b0});
        // spurious response sets the sticky error
        vecs.push_back('{2'b00, 1'b0, 1'b1, 32'h4444_0001, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 1'b0});
        vecs.push_back('{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 1'b1});
        vecs.push_back('{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 3'd0, 1'b1});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 32'h4444_0002, 1'b0, 1'b0, 2'b00, 2'b01, 3'd1, 1'b1});
        vecs.push_back('{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 3'd0, 1'b1});

        reset = 1'b1;
        d_req = 2'b11; d_aok = 1'b0; d_dok = 1'b0; d_s_rdata = '0;
        r_req = 4'b0000; r_aok = 1'b0; r_dok = 1'b0; r_s_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset s_req", d_s_req, 1'b0);
        check("reset outstanding", d_out, 3'd0);
        check("reset err_unexp", d_err, 1'b0);
        check("reset m_addr_ok", d_addr_ok, 2'b00);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            d_req = vecs[i].req; d_aok = vecs[i].aok; d_dok = vecs[i].dok; d_s_rdata = vecs[i].rdata;
            #1;
            $display("row %0d req=%b aok=%b dok=%b -> s_req=%b s_addr=%h addr_ok=%b data_ok=%b out=%0d err=%b",
                     i, d_req, d_aok, d_dok, d_s_req, d_s_addr, d_addr_ok, d_data_ok, d_out, d_err);
            check($sformatf("row%0d s_req", i), d_s_req, vecs[i].exp_sreq);
            check($sformatf("row%0d m_addr_ok", i), d_addr_ok, vecs[i].exp_aok);
            check($sformatf("row%0d m_data_ok", i), d_data_ok, vecs[i].exp_dok);
            check($sformatf("row%0d outstanding", i), d_out, vecs[i].exp_out);
            check($sformatf("row%0d err_unexp", i), d_err, vecs[i].exp_err);
            if (vecs[i].exp_sreq) begin
                check($sformatf("row%0d s_addr", i), d_s_addr, vecs[i].exp_ch ? A1 : A0);
                check($sformatf("row%0d s_wdata", i), d_s_wdata, vecs[i].exp_ch ? W1 : W0);
                check($sformatf("row%0d s_wr", i), d_s_wr, vecs[i].exp_ch);
                check($sformatf("row%0d s_size", i), d_s_size, vecs[i].exp_ch ? 2'd1 : 2'd2);
                check($sformatf("row%0d s_wstrb", i), d_s_wstrb, vecs[i].exp_ch ? 4'h3 : 4'hf);
            end
            if (vecs[i].exp_dok != 2'b00)
                check($sformatf("row%0d m_rdata", i), d_rdata, vecs[i].rdata);
            @(negedge clk);
        end

        // reset with one transaction in flight drops it and clears the sticky error
        reset = 1'b1; d_req = 2'b01; d_aok = 1'b0; d_dok = 1'b0;
        #1;
        $display("mid-reset out=%0d err=%b s_req=%b", d_out, d_err, d_s_req);
        check("midreset outstanding", d_out, 3'd0);
        check("midreset err_unexp", d_err, 1'b0);
        check("midreset s_req", d_s_req, 1'b0);
        @(negedge clk);
        reset = 1'b0; d_req = 2'b00; d_dok = 1'b1;
        #1;
        $display("post-reset response data_ok=%b", d_data_ok);
        check("postreset m_data_ok", d_data_ok, 2'b00);
        @(negedge clk);
        d_dok = 1'b0;
        #1;
        check("postreset err_unexp", d_err, 1'b1);

        // round-robin: every channel requesting, one response per cycle keeps the FIFO draining
        r_req = 4'b1111; r_aok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            r_dok = (k > 0);
            r_s_rdata = 32'h5000_0000 + 32'(k);
            #1;
            $display("rr cycle %0d addr_ok=%b data_ok=%b s_addr=%h out=%0d", k, r_addr_ok, r_data_ok, r_s_addr, r_out);
            check($sformatf("rr%0d m_addr_ok", k), r_addr_ok, one << (k % 4));
            check($sformatf("rr%0d s_addr", k), r_s_addr, 32'h10 * (32'(k % 4) + 1));
            check($sformatf("rr%0d m_data_ok", k), r_data_ok, (k > 0) ? (one << ((k - 1) % 4)) : 4'b0000);
            check($sformatf("rr%0d outstanding", k), r_out, (k > 0) ? 3'd1 : 3'd0);
            @(negedge clk);
        end
        r_req = 4'b0000; r_aok = 1'b0; r_dok = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
